// File: rtl/jacaranda_pkg.sv
// jacaranda_pkg: shared constants, state encodings and divisor helper for the UART boot loader
package jacaranda_pkg;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [15:0] MIN_CLK_DIV = 16'd4;
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CHK} ld_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return d < MIN_CLK_DIV ? MIN_CLK_DIV : d;
  endfunction
endpackage

// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: 8-bit instruction memory write port shared with the Wishbone writer
interface uart_boot_loader_if;
  logic [7:0] instr_mem_addr;
  logic [7:0] instr_mem_data;
  logic instr_mem_en;
  modport master(output instr_mem_addr, instr_mem_data, instr_mem_en);
  modport slave(input instr_mem_addr, instr_mem_data, instr_mem_en);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-flop sync, glitch-rejecting start check and stop-bit framing check
module uart_rx_core
  import jacaranda_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] div,
  input  logic        rx,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err,
  output logic        start_seen,
  output logic        busy
);
  rx_state_t state;
  logic [2:0] sync;
  logic [15:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic fall;
  logic [15:0] half;
  logic [15:0] last;
  // sync[1] is the synchronised line, sync[2] its previous value for edge detection
  assign fall = sync[2] & ~sync[1];
  assign half = (div >> 1) - 16'd1;
  assign last = div - 16'd1;
  assign busy = state != RX_IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RX_IDLE;
      sync <= '1;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      byte_valid <= 1'b0;
      byte_data <= '0;
      frame_err <= 1'b0;
      start_seen <= 1'b0;
    end else begin
      sync <= {sync[1:0], rx};
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      start_seen <= 1'b0;
      cnt <= cnt + 16'd1;
      if (!enable) state <= RX_IDLE;
      else case (state)
        RX_IDLE: if (fall) begin
          state <= RX_START;
          cnt <= '0;
          start_seen <= 1'b1;
        end
        RX_START: if (cnt == half) begin
          state <= sync[1] ? RX_IDLE : RX_DATA;
          cnt <= '0;
          bit_idx <= '0;
        end
        RX_DATA: if (cnt == last) begin
          shift <= {sync[1], shift[7:1]};
          bit_idx <= bit_idx + 3'd1;
          cnt <= '0;
          if (bit_idx == 3'd7) state <= RX_STOP;
        end
        RX_STOP: if (cnt == last) begin
          state <= RX_IDLE;
          byte_valid <= sync[1];
          frame_err <= ~sync[1];
          byte_data <= shift;
        end
        default: state <= RX_IDLE;
      endcase
    end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads SYNC/ADDR/LEN/data/CHK frames from a UART into instruction memory,
// holding the CPU while a frame is in flight
module uart_boot_loader
  import jacaranda_pkg::*;
#(
  parameter int TIMEOUT_BITS = 32,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      enable,
  input  logic [15:0]               clk_div,
  input  logic                      rx,
  uart_boot_loader_if.master        mem,
  output logic                      cpu_hold,
  output logic                      done,
  output logic                      err
);
  ld_state_t state;
  logic [15:0] div;
  logic [7:0] addr;
  logic [7:0] cnt;
  logic [7:0] sum;
  logic [31:0] tmo;
  logic [31:0] tmo_last;
  logic bv;
  logic fe;
  logic ss;
  logic rx_busy;
  logic [7:0] bd;
  assign tmo_last = 32'(TIMEOUT_BITS) * {16'd0, div} - 32'd1;
  uart_rx_core u_rx (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .enable(enable),
    .div(div),
    .rx(rx),
    .byte_valid(bv),
    .byte_data(bd),
    .frame_err(fe),
    .start_seen(ss),
    .busy(rx_busy)
  );
  // cnt holds remaining bytes minus one, so LEN=0 naturally yields 256 writes
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      div <= MIN_CLK_DIV;
      addr <= '0;
      cnt <= '0;
      sum <= '0;
      tmo <= '0;
      mem.instr_mem_en <= 1'b0;
      mem.instr_mem_addr <= '0;
      mem.instr_mem_data <= '0;
      cpu_hold <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      mem.instr_mem_en <= 1'b0;
      done <= 1'b0;
      cpu_hold <= state != IDLE;
      tmo <= (state == IDLE || ss) ? '0 : tmo + 32'd1;
      if (state == IDLE && !rx_busy) div <= eff_div(clk_div);
      if (state != IDLE && !enable) state <= IDLE;
      else if (state != IDLE && fe) begin
        err <= 1'b1;
        state <= IDLE;
      end else if (bv) case (state)
        IDLE: if (bd == SYNC_BYTE) begin
          state <= ADDR;
          err <= 1'b0;
        end
        ADDR: begin
          addr <= bd;
          sum <= bd;
          state <= LEN;
        end
        LEN: begin
          cnt <= bd - 8'd1;
          sum <= sum + bd;
          state <= DATA;
        end
        DATA: begin
          mem.instr_mem_en <= 1'b1;
          mem.instr_mem_addr <= addr;
          mem.instr_mem_data <= bd;
          addr <= addr + 8'd1;
          sum <= sum + bd;
          cnt <= cnt - 8'd1;
          if (cnt == 8'd0) state <= CHK;
        end
        CHK: begin
          done <= bd == sum;
          err <= bd != sum;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      else if (state != IDLE && tmo == tmo_last) begin
        err <= 1'b1;
        state <= IDLE;
      end
    end
endmodule
